tt_selftest_harness: RTL
========================

// Module: tt_selftest_harness
// PURPOSE
//  On-chip, parametrised successor to the bench harness around the tt_um_* top level.
//  - Sequences DUT reset.
//  - Drives pseudo-random ui_in vectors from an LFSR.
//  - Compacts uo_out into a MISR signature and flags pass/fail against a golden value.
//  - Sits beside the user project; muxed onto its pins when self-test is selected.
// PARAMETERS
//  UI_W        8        width of driven DUT input bus (1..16)
//  UO_W        8        width of sampled DUT output bus (1..16)
//  RST_CYCLES  5        cycles dut_rst_n is held low before vectors (>=1)
//  VEC_COUNT   256      number of vector cycles in RUN (>=1)
//  SEED        16'hACE1 LFSR start value (nonzero)
//  GOLDEN      16'h0000 expected final MISR signature
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst_n       in   1      synchronous reset, active low
//  start       in   1      1-cycle request; honoured only in IDLE or DONE
//  busy        out  1      high in RESET_HOLD and RUN
//  done        out  1      high in DONE until next start or reset
//  pass        out  1      valid when done; 1 iff signature==GOLDEN
//  signature   out  16     current MISR value
//  dut_rst_n   out  1      reset to DUT
//  dut_ui_in   out  UI_W   stimulus to DUT
//  dut_uo_out  in   UO_W   response from DUT
// BEHAVIOUR
//  - Reset (rst_n==0 at an edge): state=IDLE, lfsr=SEED, sig=0, counters=0.
//    - busy=0, done=0, pass=0, dut_rst_n=0, dut_ui_in=0.
//    - Same values whether in IDLE or mid-RUN; no partial result survives.
//  - All outputs registered. dut_rst_n=1 in IDLE/DONE after first non-reset edge.
//  - FSM: IDLE -> RESET_HOLD -> RUN -> DONE.
//    - IDLE/DONE: start=1 -> RESET_HOLD; lfsr=SEED, sig=0, done=0, pass=0, cnt=0.
//    - RESET_HOLD: dut_rst_n=0, dut_ui_in=0 for exactly RST_CYCLES cycles, then RUN.
//    - RUN: exactly VEC_COUNT cycles, dut_rst_n=1.
//      - Each cycle: dut_ui_in<=lfsr[UI_W-1:0], lfsr advances, MISR samples dut_uo_out.
//      - After the last cycle -> DONE.
//    - DONE: done=1, pass=(sig==GOLDEN), dut_ui_in=0, state holds.
//  - start while busy ignored (no restart, no effect). start in DONE restarts from RESET_HOLD.
//  - LFSR: 16-bit Fibonacci, lfsr<={lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//  - MISR: fb=sig[15]^sig[13]^sig[12]^sig[10];
//    sig<={sig[14:0],fb} ^ zero-extended dut_uo_out.
//  - Latency: start edge -> busy=1 next cycle; busy high RST_CYCLES+VEC_COUNT cycles;
//    done asserts the cycle busy drops.
//  - Counter widths from $clog2 of parameter+1; no wrap at VEC_COUNT=2^n.
// CONFIGURATION
//  - Macro SELFTEST_SEED_PORT_EN.
//  - Defined: extra input seed_in[15:0], sampled on accepted start, replaces SEED.
//    - seed_in==0 loads SEED instead (LFSR lock-up guard).
//  - Undefined: no seed_in port; SEED parameter always used.
// TESTING
//  1. Defaults, dut_uo_out tied 0, start pulse.
//     -> busy 261 cycles, dut_rst_n low for first 5; sig=0, done=1, pass=1.
//  2. First RUN cycle: dut_ui_in=8'hE1, lfsr=16'h59C3; second cycle dut_ui_in=8'hC3.
//  3. VEC_COUNT=1, dut_uo_out=8'h01.
//     -> signature=16'h0001; with GOLDEN=0: pass=0, done=1.
//  4. start pulsed mid-RUN.
//     -> ignored, run length unchanged.
//     Start from DONE -> new run, identical signature.
//  5. rst_n low one edge mid-RUN.
//     -> next cycle busy=0, done=0, dut_rst_n=0, sig=0, lfsr=16'hACE1.
//  6. SELFTEST_SEED_PORT_EN defined, seed_in=16'h0001.
//     -> first RUN dut_ui_in=8'h01; seed_in=0 behaves as test 2.

Source files
------------

// File: rtl/tt_selftest_harness.sv
// tt_selftest_harness
//   On-chip self-test harness for a tt_um_* style user project. It sequences
//   the project's reset, drives pseudo-random vectors from a 16-bit Fibonacci
//   LFSR onto the project inputs, compacts the project outputs into a 16-bit
//   MISR signature and reports pass/fail against a golden signature.
//
//   Sequence: IDLE -> RESET_HOLD (RST_CYCLES) -> RUN (VEC_COUNT) -> DONE.
//
// Parameters
//   UI_W        width of the driven project input bus (1..16)
//   UO_W        width of the sampled project output bus (1..16)
//   RST_CYCLES  cycles dut_rst_n is held low before vectors (>=1)
//   VEC_COUNT   number of vector cycles in RUN (>=1)
//   SEED        LFSR start value (nonzero)
//   GOLDEN      expected final MISR signature
//
// Ports
//   clk         clock, all logic on rising edge
//   rst_n       synchronous reset, active low
//   start       one-cycle request, honoured only in IDLE or DONE
//   seed_in     (only with SELFTEST_SEED_PORT_EN) run seed, 0 selects SEED
//   busy        high during RESET_HOLD and RUN
//   done        high in DONE until the next start or reset
//   pass        valid while done: signature == GOLDEN
//   signature   current MISR value
//   dut_rst_n   reset to the project
//   dut_ui_in   stimulus to the project
//   dut_uo_out  response from the project
//
// Configuration
//   SELFTEST_SEED_PORT_EN  when defined adds seed_in; sampled on an accepted
//                          start and used instead of SEED (zero falls back to
//                          SEED so the LFSR can never lock up).
//
// All outputs are registered.

module tt_selftest_harness #(
  parameter int          UI_W       = 8,
  parameter int          UO_W       = 8,
  parameter int          RST_CYCLES = 5,
  parameter int          VEC_COUNT  = 256,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [15:0] GOLDEN     = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef SELFTEST_SEED_PORT_EN
  input  logic [15:0]     seed_in,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature,
  output logic            dut_rst_n,
  output logic [UI_W-1:0] dut_ui_in,
  input  logic [UO_W-1:0] dut_uo_out
);

  // Counters are sized to hold the parameter value itself, so a count of
  // exactly 2^n never wraps.
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int VW = $clog2(VEC_COUNT + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [VW-1:0] VEC_LAST = VW'(VEC_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [15:0]     lfsr, lfsr_d;
  logic [15:0]     sig, sig_d;
  logic [RW-1:0]   rst_cnt, rst_cnt_d;
  logic [VW-1:0]   vec_cnt, vec_cnt_d;
  logic            busy_d, done_d, pass_d, dut_rst_n_d;
  logic [UI_W-1:0] dut_ui_in_d;
  logic [15:0]     uo_ext;
  logic [15:0]     start_seed;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s,
                                            input logic [15:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ d;
  endfunction

  always_comb begin
    uo_ext             = '0;
    uo_ext[UO_W-1:0]   = dut_uo_out;
  end

`ifdef SELFTEST_SEED_PORT_EN
  // A zero seed would freeze the LFSR, so it selects the built-in seed.
  assign start_seed = (seed_in == 16'h0000) ? SEED : seed_in;
`else
  assign start_seed = SEED;
`endif

  assign signature = sig;

  always_comb begin
    state_d     = state;
    lfsr_d      = lfsr;
    sig_d       = sig;
    rst_cnt_d   = rst_cnt;
    vec_cnt_d   = vec_cnt;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    dut_rst_n_d = dut_rst_n;
    dut_ui_in_d = dut_ui_in;

    case (state)
      ST_IDLE, ST_DONE: begin
        dut_rst_n_d = 1'b1;
        dut_ui_in_d = '0;
        if (start) begin
          state_d     = ST_RESET_HOLD;
          lfsr_d      = start_seed;
          sig_d       = '0;
          rst_cnt_d   = '0;
          vec_cnt_d   = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          dut_rst_n_d = 1'b0;
        end
      end

      ST_RESET_HOLD: begin
        dut_rst_n_d = 1'b0;
        dut_ui_in_d = '0;
        if (rst_cnt == RST_LAST) begin
          // Leaving reset hold presents the first vector in the same edge,
          // so the project sees it on its first cycle out of reset.
          state_d     = ST_RUN;
          dut_rst_n_d = 1'b1;
          dut_ui_in_d = lfsr[UI_W-1:0];
          lfsr_d      = lfsr_step(lfsr);
        end else begin
          rst_cnt_d = rst_cnt + RW'(1);
        end
      end

      ST_RUN: begin
        // The response to the vector presented this cycle is compacted at
        // the closing edge; the last edge also settles the verdict.
        sig_d = misr_step(sig, uo_ext);
        if (vec_cnt == VEC_LAST) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = (sig_d == GOLDEN);
          dut_ui_in_d = '0;
        end else begin
          vec_cnt_d   = vec_cnt + VW'(1);
          dut_ui_in_d = lfsr[UI_W-1:0];
          lfsr_d      = lfsr_step(lfsr);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= SEED;
      sig       <= '0;
      rst_cnt   <= '0;
      vec_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_rst_n <= 1'b0;
      dut_ui_in <= '0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      sig       <= sig_d;
      rst_cnt   <= rst_cnt_d;
      vec_cnt   <= vec_cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      dut_rst_n <= dut_rst_n_d;
      dut_ui_in <= dut_ui_in_d;
    end
  end

endmodule
